// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, synchronous imem request, IF/ID register with stall hold
module if_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_flush,
  input  logic            if2id_stall,
  input  logic [XLEN-1:0] branch_target,
  output logic            instr_req,
  output logic [XLEN-1:0] instr_addr,
  input  logic [31:0]     instr_rdata,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            id_valid
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] id_pc_next;
  logic            id_valid_next;
  logic            hold_valid;
  logic            hold_valid_next;
  logic [31:0]     hold_instr;
  logic [31:0]     hold_instr_next;
  logic            issue;

  // A flush always issues the redirect fetch, even when decode is stalled.
  assign issue      = if_flush | ~if2id_stall;
  assign instr_req  = ~rst & issue;
  assign instr_addr = if_flush ? branch_target : pc;

  // Memory data is stale after a cycle without a request; the hold copy covers that.
  assign id_instr   = hold_valid ? hold_instr : instr_rdata;

  always_comb begin
    pc_next         = pc;
    id_pc_next      = id_pc;
    id_valid_next   = id_valid;
    hold_valid_next = hold_valid;
    hold_instr_next = hold_instr;
    if (issue) begin
      pc_next         = instr_addr + PC_STEP;
      id_pc_next      = instr_addr;
      id_valid_next   = 1'b1;
      hold_valid_next = 1'b0;
    end else if (!hold_valid) begin
      hold_instr_next = instr_rdata;
      hold_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      id_pc      <= '0;
      id_valid   <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
    end else begin
      pc         <= pc_next;
      id_pc      <= id_pc_next;
      id_valid   <= id_valid_next;
      hold_valid <= hold_valid_next;
      hold_instr <= hold_instr_next;
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with the IF/ID pipeline register, consuming the hazard unit's if_flush / if2id_stall controls.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents {id_pc, id_instr, id_valid} to decode.
- Holds the fetched instruction stable across stalls using a skid/hold register.
- Redirects fetch to the branch target on flush with no extra bubble.

Parameters:
XLEN, 32, data/address width
RESET_VECTOR, 32'h0, first fetch address after reset

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
if_flush  input  1  kill the current IF fetch and redirect to branch_target
if2id_stall  input  1  freeze the PC and the IF/ID register
branch_target  input  XLEN  redirect address, sampled only when if_flush=1
instr_req  output  1  instruction memory read enable
instr_addr  output  XLEN  instruction memory read address, word aligned
instr_rdata  input  32  read data, valid the cycle after instr_req=1
id_pc  output  XLEN  PC of the instruction in ID
id_instr  output  32  instruction in ID
id_valid  output  1  ID holds a live instruction

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
  - On rst: pc=RESET_VECTOR, id_pc=0, id_valid=0, hold_valid=0, hold_instr=0.
- Output values while rst is high:
  - instr_req=0.
  - id_instr=instr_rdata (don't-care, because id_valid=0).
- Fetch issue, combinational:
  - instr_req = ~rst & (if_flush | ~if2id_stall).
  - instr_addr = if_flush ? branch_target : pc.
- Priority is if_flush > if2id_stall > advance. Flush and stall asserted together behaves as flush.
- Advance (flush=0, stall=0), at the clock edge:
  - pc <= pc+4.
  - id_pc <= pc.
  - id_valid <= 1.
  - hold_valid <= 0.
- Flush, at the clock edge:
  - pc <= branch_target+4.
  - id_pc <= branch_target.
  - id_valid <= 1.
  - hold_valid <= 0.
  - The wrong-path fetch is never exposed. The ID-stage kill of the older instruction belongs to the decode stage, not to this block.
- Stall (flush=0, stall=1):
  - pc, id_pc and id_valid hold.
  - No memory read is issued.
  - If hold_valid=0: hold_instr <= instr_rdata and hold_valid <= 1 (first stall cycle capture).
  - If hold_valid=1: hold_instr and hold_valid hold.
- id_instr = hold_valid ? hold_instr : instr_rdata. It is stable through any stall length and matches id_pc.
- instr_rdata is not sampled when it is stale, i.e. the cycle after instr_req=0. The hold register covers exactly that case.
- Address arithmetic:
  - pc+4 wraps modulo 2^XLEN.
  - branch_target bits[1:0] are passed through unmodified. Alignment exceptions are handled elsewhere.
- First cycle after rst deasserts:
  - instr_req=1, instr_addr=RESET_VECTOR.
  - id_valid rises on the following edge.
- Reset mid-stall or mid-flush: all state clears immediately. Hold contents are lost, and fetch restarts at RESET_VECTOR.
- Throughput: 1 instruction per cycle when unstalled.
- Branch redirect costs zero extra bubbles in this block.
- Latency from the issue edge to id_valid is 1 cycle.

Test Plan:
1. Reset release with RESET_VECTOR=0 and memory word i = 0x1000+i:
   - instr_addr is 0, 4, 8 on consecutive cycles.
   - id_pc/id_instr are (0, 0x1000), (4, 0x1001), (8, 0x1002).
   - id_valid=1 from the 2nd cycle onward.
2. Stall for 3 cycles while id_pc=8:
   - instr_req=0 and id_pc=8 throughout.
   - id_instr=0x1002 on every stall cycle, even though the memory model drives random instr_rdata when not read.
   - After release, id_pc=12 / id_instr=0x1003.
3. if_flush=1 with branch_target=0x40 while pc=0x10:
   - instr_addr=0x40 in the same cycle.
   - Next cycle: id_pc=0x40, id_instr=mem[0x40].
   - Then instr_addr=0x44.
   - No wrong-path instruction (0x10) appears in ID.
4. if_flush=1 together with if2id_stall=1, branch_target=0x80:
   - Behaves identically to scenario 3 (id_pc=0x80, hold_valid cleared).
   - A stale hold_instr must not appear on id_instr.
5. Assert rst asynchronously mid-stall, with hold_valid=1 and pc=0x24:
   - id_valid=0 and instr_req=0 immediately, without waiting for a clock edge.
   - After release, fetch restarts at RESET_VECTOR.
6. pc=0xFFFFFFFC with XLEN=32, no stall:
   - The next fetch address is 0x00000000 (wrap).
   - id_pc=0xFFFFFFFC pairs with the correct instruction.
